regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- Register file and write-back end for the multi-cycle CPU: 32 x 32-bit general registers.
- Two combinational read ports feed the A/B operand latches.
- One write port accepts write-back requests from the WB state.
- Writes pass through a one-entry write-back buffer and commit to the array one clock later. Reads forward from that buffer, so the latency is invisible to the datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; the array depth is 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- RegWre  input  1  write-back request, valid for one cycle.
- write_reg  input  ADDR_W  destination register index.
- write_data  input  DATA_W  write-back value.
- read_reg1  input  ADDR_W  port-1 (rs) index.
- read_reg2  input  ADDR_W  port-2 (rt) index.
- read_data1  output  DATA_W  port-1 data, combinational.
- read_data2  output  DATA_W  port-2 data, combinational.
- wb_busy  output  1  high while the write-back buffer holds an uncommitted write.

Behaviour:
- Storage: array regs[0..31], write-back buffer {wb_valid, wb_addr, wb_data}.
- Reset (asynchronous, Reset=1):
  - all regs cleared to 0; wb_valid=0, wb_addr=0, wb_data=0; wb_busy=0.
  - read_data1/2 return 0 for every index while held in reset.
  - Reset asserted mid-operation discards any pending buffered write; it never commits.
- Capture, at the rising edge when RegWre=1 and write_reg!=0:
  - wb_valid<=1, wb_addr<=write_reg, wb_data<=write_data.
- RegWre=1 with write_reg=0 is ignored: buffer not loaded; the pending write still drains normally.
- Commit: at every rising edge with wb_valid=1, regs[wb_addr]<=wb_data.
  - wb_valid then clears unless a new capture occurs on the same edge.
- Simultaneous commit and capture (back-to-back writes): the old entry commits and the new entry loads on the same edge. No stall and no loss.
- Back-to-back writes to the same index: the older value commits first, then the newer one. The final value is the newest.
- Read mux, per port independently:
  - index 0 -> 0;
  - else if wb_valid and wb_addr==index -> wb_data (forward);
  - else regs[index].
- Read-during-capture: the value presented on write_data in the same cycle is NOT forwarded. Reads see it from the next cycle onward, through the buffer.
- Latency: a write presented in cycle N is readable from cycle N+1 and resident in the array from the edge ending cycle N+1.
- wb_busy = wb_valid.
- Register 0 is never written; reading it always returns 0.
- Both ports may read the same index; each returns an identical value.

Optional Feature:
- Macro: REGFILE_DBGPORT_EN.
- Defined:
  - adds ports dbg_reg (input, ADDR_W) and dbg_data (output, DATA_W), combinational, using the same forwarding mux as read ports.
  - adds wr_count (output, 32), which increments by 1 on every commit and resets to 0; it wraps 0xFFFFFFFF -> 0.
- Undefined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset pulse, then read all indices on both ports -> every read_data1/2 = 0; wb_busy=0.
- RegWre=1, write_reg=5, write_data=0xDEADBEEF in cycle N; read_reg1=5 in N+1 and N+2 -> 0xDEADBEEF in both cycles (forwarded, then from array); wb_busy=1 in N+1 only.
- Writes to r3=0x11111111 then r3=0x22222222 on consecutive cycles; read_reg2=3 -> 0x11111111 in cycle 2, then 0x22222222 from cycle 3 onward.
- Write r0=0xFFFFFFFF -> read_reg1=0 returns 0; wb_busy stays 0.
- Write r7=0x12345678, assert Reset in the next cycle before commit, release -> r7 reads 0.
- REGFILE_DBGPORT_EN defined: 3 non-zero writes -> wr_count=3; dbg_reg=7 returns the last r7 value; Reset -> wr_count=0.

Source files
------------

// File: rtl/regfile_wb.sv
// 32 x 32-bit register file with a one-entry write-back buffer that forwards to both read ports.
// Optional debug read port and commit counter are enabled by defining REGFILE_DBGPORT_EN.
module regfile_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              RegWre,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              wb_busy
`ifdef REGFILE_DBGPORT_EN
   ,
   input  logic [ADDR_W-1:0] dbg_reg,
   output logic [DATA_W-1:0] dbg_data,
   output logic [31:0]       wr_count
`endif
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              capture;

   assign capture = RegWre && (write_reg != '0);
   assign wb_busy = wb_valid;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wb_valid) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Buffer drains every edge; a capture on the same edge simply refills it.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= capture;
         if (capture) begin
            wb_addr <= write_reg;
            wb_data <= write_data;
         end
      end
   end

   function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] idx);
      if (idx == '0)
         return '0;
      else if (wb_valid && (wb_addr == idx))
         return wb_data;
      else
         return regs[idx];
   endfunction

   always_comb begin
      read_data1 = read_mux(read_reg1);
      read_data2 = read_mux(read_reg2);
   end

`ifdef REGFILE_DBGPORT_EN
   always_comb begin
      dbg_data = read_mux(dbg_reg);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         wr_count <= '0;
      else if (wb_valid)
         wr_count <= wr_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus pushes expected reads from an architectural model,
// a negedge monitor pops and compares. Define REGFILE_DBGPORT_EN to also check the debug port.
module tb_regfile_wb;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        RegWre;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        wb_busy;
   logic [4:0]  dbg_reg;
`ifdef REGFILE_DBGPORT_EN
   logic [31:0] dbg_data;
   logic [31:0] wr_count;
`endif

   always #5 CLK = ~CLK;

   regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .RegWre     (RegWre),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .wb_busy    (wb_busy)
`ifdef REGFILE_DBGPORT_EN
      ,
      .dbg_reg    (dbg_reg),
      .dbg_data   (dbg_data),
      .wr_count   (wr_count)
`endif
   );

   typedef struct {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        busy;
      logic [31:0] dbg;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Architectural view: a write issued in a cycle is visible to reads from the next cycle.
   logic [31:0] model [32];
   logic        pend;
   logic [31:0] commits;

   function automatic logic [31:0] model_rd(input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : model[idx];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("read_data1", read_data1, e.rd1);
         check("read_data2", read_data2, e.rd2);
         check("wb_busy", {31'd0, wb_busy}, {31'd0, e.busy});
`ifdef REGFILE_DBGPORT_EN
         check("dbg_data", dbg_data, e.dbg);
         check("wr_count", wr_count, e.cnt);
`endif
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      pend    = 1'b0;
      commits = 32'd0;
   endtask

   task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      exp_t e;
      @(posedge CLK);
      #1;
      Reset      = 1'b0;
      RegWre     = we;
      write_reg  = wa;
      write_data = wd;
      read_reg1  = r1;
      read_reg2  = r2;
      dbg_reg    = rd;
      e.rd1  = model_rd(r1);
      e.rd2  = model_rd(r2);
      e.dbg  = model_rd(rd);
      e.busy = pend;
      e.cnt  = commits;
      sb.push_back(e);
      if (pend) commits = commits + 32'd1;
      pend = we && (wa != 5'd0);
      if (pend) model[wa] = wd;
   endtask

   task automatic reset_cycle(input logic [4:0] r1, input logic [4:0] r2);
      exp_t e;
      @(posedge CLK);
      #1;
      Reset      = 1'b1;
      RegWre     = 1'b0;
      write_reg  = 5'd0;
      write_data = 32'd0;
      read_reg1  = r1;
      read_reg2  = r2;
      dbg_reg    = r1;
      model_clear();
      e.rd1  = 32'd0;
      e.rd2  = 32'd0;
      e.dbg  = 32'd0;
      e.busy = 1'b0;
      e.cnt  = 32'd0;
      sb.push_back(e);
   endtask

   initial begin
      Reset      = 1'b1;
      RegWre     = 1'b0;
      write_reg  = '0;
      write_data = '0;
      read_reg1  = '0;
      read_reg2  = '0;
      dbg_reg    = '0;
      model_clear();

      for (int i = 0; i < 32; i++) reset_cycle(5'(i), 5'(31 - i));

      // Forward then array read of r5
      cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
      cycle(1'b0, 5'd0, 32'd0,        5'd5, 5'd5, 5'd5);
      cycle(1'b0, 5'd0, 32'd0,        5'd5, 5'd5, 5'd5);

      // Back-to-back writes to r3
      cycle(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd3, 5'd3);
      cycle(1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3, 5'd3);
      cycle(1'b0, 5'd0, 32'd0,        5'd3, 5'd3, 5'd3);
      cycle(1'b0, 5'd0, 32'd0,        5'd3, 5'd3, 5'd3);

      // r0 writes are ignored
      cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      cycle(1'b0, 5'd0, 32'd0,        5'd0, 5'd0, 5'd0);

      // Reset discards a pending write
      cycle(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7);
      reset_cycle(5'd7, 5'd7);
      cycle(1'b0, 5'd0, 32'd0,        5'd7, 5'd7, 5'd7);
      cycle(1'b0, 5'd0, 32'd0,        5'd7, 5'd7, 5'd7);

      // Counter and debug port
      cycle(1'b1, 5'd7, 32'hAAAA0001, 5'd7, 5'd1, 5'd7);
      cycle(1'b1, 5'd1, 32'hAAAA0002, 5'd7, 5'd1, 5'd7);
      cycle(1'b1, 5'd7, 32'hAAAA0003, 5'd7, 5'd1, 5'd7);
      cycle(1'b0, 5'd0, 32'd0,        5'd7, 5'd1, 5'd7);
      cycle(1'b0, 5'd0, 32'd0,        5'd7, 5'd1, 5'd7);

      for (int n = 0; n < 400; n++) begin
         logic [4:0] r1;
         logic [4:0] r2;
         r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 4) == 0) ? r1 : 5'($urandom_range(0, 7));
         if ($urandom_range(0, 60) == 0)
            reset_cycle(r1, r2);
         else
            cycle(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                  r1, r2, 5'($urandom_range(0, 7)));
      end
      cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd3);

      for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge CLK);
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
